systolic_mac_engine: RTL and testbench

Parametrised output-stationary systolic matrix-multiply engine, C[ROWS×COLS] (+)= A[ROWS×K]·B[K×COLS], with runtime K length, accumulate/clear mode, per-column enable mask and a valid/ready result drain. It is the next-generation matrix core of the Kalman datapath: operands stream in one K-slice per beat under handshake, instead of being presented as whole matrices, and results leave row by row. Integer (signed fixed-point) arithmetic; the surrounding blocks handle scaling.

---
 rtl/systolic_mac_engine.sv | 173 +++++++++++++++++
 tb/tb_systolic_mac_engine.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_engine.sv
// systolic_mac_engine: output-stationary systolic MAC array, C (+)= A*B fed one K-slice per beat, drained row by row.
// Lane n of a_vec/b_vec/out_data sits at [n*W +: W]; define SYSTOLIC_SAT_EN for saturating accumulators.
module systolic_mac_engine #(
  parameter int DWIDTH = 32,
  parameter int ACC_W = 80,
  parameter int ROWS = 12,
  parameter int COLS = 12,
  parameter int KMAX = 256,
  localparam int KW = $clog2(KMAX + 1),
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   acc_mode,
  input  logic [COLS-1:0]        col_mask,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DWIDTH-1:0] a_vec,
  input  logic [COLS*DWIDTH-1:0] b_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RW-1:0]          out_row,
  output logic [COLS*ACC_W-1:0]  out_data,
  output logic                   done,
  output logic                   sat_flag
);
  localparam int FW = $clog2(ROWS + COLS);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
  state_t r_state, w_next;
  logic [KW-1:0] r_klen, r_cnt, w_klen;
  logic [FW-1:0] r_fl;
  logic [RW-1:0] r_row, w_nrow;
  logic [COLS-1:0] r_mask, w_mask;
  logic r_done, r_sat, w_start, w_beat, w_clr, w_run, w_any_ovf;
  logic signed [DWIDTH-1:0] w_ai [ROWS];
  logic signed [DWIDTH-1:0] w_bj [COLS];
  logic signed [DWIDTH-1:0] w_ra [ROWS][COLS];
  logic signed [DWIDTH-1:0] w_rb [ROWS][COLS];
  logic signed [ACC_W-1:0] w_acc [ROWS][COLS];
  logic [COLS*ACC_W-1:0] r_out;
  assign w_start = r_state == IDLE && start;
  assign w_beat = r_state == LOAD && in_valid;
  assign w_clr = w_start && !acc_mode;
  assign w_run = r_state == LOAD || r_state == FLUSH;
  assign w_klen = k_len > KW'(KMAX) ? KW'(KMAX) : k_len;
  assign w_mask = w_start ? col_mask : r_mask;
  assign w_nrow = (r_state == DRAIN && out_ready) ? (r_row == RW'(ROWS - 1) ? '0 : r_row + RW'(1)) : r_row;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = w_klen == '0 ? DRAIN : LOAD;
      LOAD:  if (w_beat && r_cnt == r_klen - KW'(1)) w_next = FLUSH;
      FLUSH: if (r_fl == FW'(ROWS + COLS - 2)) w_next = DRAIN;
      DRAIN: if (out_ready && r_row == RW'(ROWS - 1)) w_next = IDLE;
    endcase
  end
  always_comb begin
    busy = r_state != IDLE;
    in_ready = r_state == LOAD;
    out_valid = r_state == DRAIN;
    out_row = r_row;
    out_data = r_out;
    done = r_done;
    sat_flag = r_sat;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_klen <= '0;
      r_cnt <= '0;
      r_fl <= '0;
      r_row <= '0;
      r_mask <= '0;
      r_done <= 1'b0;
      r_sat <= 1'b0;
      r_out <= '0;
    end else begin
      r_klen <= w_start ? w_klen : r_klen;
      r_cnt <= w_start ? '0 : r_cnt + KW'(w_beat);
      r_fl <= r_state == FLUSH ? r_fl + FW'(1) : '0;
      r_row <= w_nrow;
      r_mask <= w_mask;
      r_done <= r_state == DRAIN && out_ready && r_row == RW'(ROWS - 1);
      r_sat <= !w_clr && (r_sat || w_any_ovf);
      // preload the row that will be presented next cycle so out_data is a plain register
      if (w_next == DRAIN)
        for (int c = 0; c < COLS; c++)
          r_out[c*ACC_W +: ACC_W] <= (w_clr || !w_mask[c]) ? '0 : w_acc[w_nrow][c];
    end
  end
  for (genvar i = 0; i < ROWS; i++) begin : g_ask
    logic signed [DWIDTH-1:0] w_inj;
    assign w_inj = w_beat ? a_vec[i*DWIDTH +: DWIDTH] : '0;
    if (i == 0) begin : g_z
      assign w_ai[i] = w_inj;
    end else begin : g_d
      logic signed [DWIDTH-1:0] r_sk [i];
      always_ff @(posedge clk) begin
        r_sk[0] <= rst ? '0 : w_inj;
        for (int d = 1; d < i; d++) r_sk[d] <= rst ? '0 : r_sk[d-1];
      end
      assign w_ai[i] = r_sk[i-1];
    end
  end
  for (genvar j = 0; j < COLS; j++) begin : g_bsk
    logic signed [DWIDTH-1:0] w_inj;
    assign w_inj = w_beat ? b_vec[j*DWIDTH +: DWIDTH] : '0;
    if (j == 0) begin : g_z
      assign w_bj[j] = w_inj;
    end else begin : g_d
      logic signed [DWIDTH-1:0] r_sk [j];
      always_ff @(posedge clk) begin
        r_sk[0] <= rst ? '0 : w_inj;
        for (int d = 1; d < j; d++) r_sk[d] <= rst ? '0 : r_sk[d-1];
      end
      assign w_bj[j] = r_sk[j-1];
    end
  end
`ifdef SYSTOLIC_SAT_EN
  logic w_sov [ROWS][COLS];
  always_comb begin
    w_any_ovf = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) w_any_ovf = w_any_ovf | w_sov[r][c];
  end
`else
  assign w_any_ovf = 1'b0;
`endif
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [DWIDTH-1:0] w_l, w_t, r_a, r_b;
      logic signed [2*DWIDTH-1:0] w_p;
      logic signed [ACC_W-1:0] w_s, w_res, r_acc;
      if (j == 0) begin : g_l
        assign w_l = w_ai[i];
      end else begin : g_l
        assign w_l = w_ra[i][j-1];
      end
      if (i == 0) begin : g_t
        assign w_t = w_bj[j];
      end else begin : g_t
        assign w_t = w_rb[i-1][j];
      end
      assign w_p = (2*DWIDTH)'(w_l) * (2*DWIDTH)'(w_t);
      assign w_s = r_acc + ACC_W'(w_p);
`ifdef SYSTOLIC_SAT_EN
      logic w_ovf;
      assign w_ovf = r_acc[ACC_W-1] == w_p[2*DWIDTH-1] && w_s[ACC_W-1] != r_acc[ACC_W-1];
      assign w_res = w_ovf ? {r_acc[ACC_W-1], {(ACC_W-1){!r_acc[ACC_W-1]}}} : w_s;
      assign w_sov[i][j] = w_ovf && w_run && r_mask[j];
`else
      assign w_res = w_s;
`endif
      always_ff @(posedge clk) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
          r_acc <= '0;
        end else begin
          r_a <= w_l;
          r_b <= w_t;
          r_acc <= w_clr ? '0 : (w_run && r_mask[j]) ? w_res : r_acc;
        end
      end
      assign w_ra[i][j] = r_a;
      assign w_rb[i][j] = r_b;
      assign w_acc[i][j] = r_acc;
    end
  end
endmodule

// File: tb/tb_systolic_mac_engine.sv
// tb_systolic_mac_engine: random-stimulus bench for a 4x4 engine against a matrix-level reference model.
module tb_systolic_mac_engine;
  localparam int DW = 32, AW = 64, R = 4, C = 4, KM = 8, KW = 4;
  logic clk = 1'b0;
  logic rst, start, acc_mode, in_valid, out_ready;
  logic [KW-1:0] k_len;
  logic [C-1:0] col_mask;
  logic busy, in_ready, out_valid, done, sat_flag;
  logic [R*DW-1:0] a_vec;
  logic [C*DW-1:0] b_vec;
  logic [1:0] out_row;
  logic [C*AW-1:0] out_data;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int ga [KM][R];
  int gb [KM][C];
  logic signed [63:0] mc [R][C];
  bit msat;
  logic [C-1:0] mmask;

  systolic_mac_engine #(.DWIDTH(DW), .ACC_W(AW), .ROWS(R), .COLS(C), .KMAX(KM)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .acc_mode(acc_mode), .col_mask(col_mask),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data),
    .done(done), .sat_flag(sat_flag));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [63:0] madd(input logic signed [63:0] x, input logic signed [63:0] p);
    logic signed [64:0] w;
    w = 65'(x) + 65'(p);
`ifdef SYSTOLIC_SAT_EN
    if (w > 65'sh0_7FFF_FFFF_FFFF_FFFF) begin msat = 1'b1; return 64'sh7FFF_FFFF_FFFF_FFFF; end
    if (w < -65'sh0_8000_0000_0000_0000) begin msat = 1'b1; return 64'sh8000_0000_0000_0000; end
`endif
    return w[63:0];
  endfunction

  function automatic logic [255:0] exp_row(input int r);
    logic [255:0] v;
    v = '0;
    for (int j = 0; j < C; j++) if (mmask[j]) v[j*AW +: AW] = mc[r][j];
    return v;
  endfunction

  task automatic model_clear;
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) mc[i][j] = '0;
    msat = 1'b0;
  endtask

  task automatic fill_rand(input int lim);
    for (int k = 0; k < KM; k++) begin
      for (int i = 0; i < R; i++) ga[k][i] = int'($urandom_range(2 * lim)) - lim;
      for (int j = 0; j < C; j++) gb[k][j] = int'($urandom_range(2 * lim)) - lim;
    end
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < KM; k++) begin
      for (int i = 0; i < R; i++) ga[k][i] = v;
      for (int j = 0; j < C; j++) gb[k][j] = v;
    end
  endtask

  task automatic run_job(input int k, input bit mode, input logic [C-1:0] mask, input int bub, input int stl, input bit timed);
    int kc, beat, row, t0, budget;
    bit acc;
    kc = k > KM ? KM : k;
    start = 1'b1;
    k_len = KW'(k);
    acc_mode = mode;
    col_mask = mask;
    if (!mode) model_clear();
    mmask = mask;
    t0 = cyc;
    tick();
    start = 1'b0;
    check("busy_on", busy, 1'b1);
    check("in_ready_on", in_ready, kc > 0);
    beat = 0;
    budget = 0;
    while (beat < kc && budget < 400) begin
      in_valid = $urandom_range(99) >= bub;
      for (int i = 0; i < R; i++) a_vec[i*DW +: DW] = in_valid ? ga[beat][i] : $urandom;
      for (int j = 0; j < C; j++) b_vec[j*DW +: DW] = in_valid ? gb[beat][j] : $urandom;
      start = 1'($urandom_range(1));
      k_len = KW'($urandom);
      acc = in_valid && in_ready;
      tick();
      budget++;
      if (acc) begin
        for (int i = 0; i < R; i++)
          for (int j = 0; j < C; j++)
            if (mmask[j]) mc[i][j] = madd(mc[i][j], longint'(ga[beat][i]) * longint'(gb[beat][j]));
        beat++;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (beat < kc) check("beat_timeout", beat, kc);
    else if (kc > 0) check("in_ready_drop", in_ready, 1'b0);
    budget = 0;
    while (!out_valid && budget < 100) begin
      tick();
      budget++;
    end
    check("out_valid_seen", out_valid, 1'b1);
    if (timed && kc > 0) check("ov_latency", cyc - t0, kc + R + C);
    row = 0;
    budget = 0;
    while (row < R && budget < 200) begin
      out_ready = $urandom_range(99) >= stl;
      check("out_valid", out_valid, 1'b1);
      check("out_row", out_row, row);
      check("out_data", out_data, exp_row(row));
      tick();
      budget++;
      if (out_ready) row++;
    end
    out_ready = 1'b0;
    check("done_pulse", done, 1'b1);
    check("busy_off", busy, 1'b0);
    check("sat_flag", sat_flag, msat);
    if (timed) check("done_latency", cyc - t0, kc > 0 ? kc + 2 * R + C : R + 1);
    tick();
    check("done_once", done, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    acc_mode = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    k_len = '0;
    col_mask = '0;
    a_vec = '0;
    b_vec = '0;
    mmask = '1;
    model_clear();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_row", out_row, 2'd0);
    check("rst_out_data", out_data, '0);
    check("rst_done", done, 1'b0);
    check("rst_sat", sat_flag, 1'b0);
    for (int k = 0; k < KM; k++) begin
      for (int i = 0; i < R; i++) ga[k][i] = int'(k == i);
      for (int j = 0; j < C; j++) gb[k][j] = k * 4 + j;
    end
    run_job(4, 1'b0, 4'hF, 0, 0, 1'b1);
    run_job(4, 1'b1, 4'hF, 0, 0, 1'b1);
    run_job(4, 1'b0, 4'hF, 0, 0, 1'b1);
    fill_rand(1000);
    run_job(7, 1'b0, 4'hF, 50, 30, 1'b0);
    fill_rand(1000);
    run_job(7, 1'b1, 4'hF, 50, 30, 1'b0);
    fill_rand(1000);
    run_job(3, 1'b0, 4'b0101, 0, 0, 1'b1);
    run_job(0, 1'b0, 4'hF, 0, 0, 1'b1);
    fill_rand(1000);
    run_job(12, 1'b0, 4'hF, 20, 20, 1'b0);
    fill_rand(1000);
    start = 1'b1;
    k_len = 4'd5;
    acc_mode = 1'b1;
    col_mask = 4'hF;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < R; i++) a_vec[i*DW +: DW] = ga[b][i];
      for (int j = 0; j < C; j++) b_vec[j*DW +: DW] = gb[b][j];
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    model_clear();
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_out_data", out_data, '0);
    run_job(5, 1'b1, 4'hF, 30, 30, 1'b0);
    fill_const(int'(32'h8000_0000));
    run_job(4, 1'b0, 4'hF, 0, 0, 1'b1);
    fill_rand(1000);
    run_job(2, 1'b0, 4'hF, 0, 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
